// File: rtl/dpram_be_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpram_be_pkg                                                         |
// | Shared constants, clear-sequencer states and byte-lane merge helper. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package dpram_be_pkg;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } clr_state_e;

  // One lane of a partial write: the new byte where enabled, the stored byte otherwise.
  function automatic logic [7:0] byte_merge(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       we);
    return we ? new_byte : old_byte;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dpram_be_clear_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpram_be_clear_seq                                                   |
// | Post-reset fill sequencer: walks every address once, then releases.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dpram_be_clear_seq
  import dpram_be_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic          clk,
  input  logic          rst,
  output logic          busy,
  output logic          clr_we,
  output logic [AW-1:0] clr_addr
);

  clr_state_e    state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_IDLE: begin
        state_d = ST_CLEAR;
        cnt_d   = '0;
      end
      ST_CLEAR: begin
        cnt_d = cnt_q + AW'(1);
        if (cnt_q == '1) state_d = ST_READY;
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Busy also covers the reset cycles themselves, not just the post-reset states.
  always_comb begin
    busy     = rst | (state_q != ST_READY);
    clr_we   = (state_q == ST_CLEAR) & ~rst;
    clr_addr = cnt_q;
  end

endmodule
`default_nettype wire

// File: rtl/dpram_be.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dpram_be                                                             |
// | RW port A + RO port B RAM with byte enables and selectable RDW mode. |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dpram_be
  import dpram_be_pkg::*;
#(
  parameter int          AW           = 10,
  parameter int          DW           = 32,
  parameter int          RDW_MODE     = RDW_READ_FIRST,
  parameter int          OUT_REG      = 0,
  parameter int          CLEAR_ON_RST = 0,
  parameter logic [DW-1:0] CLEAR_VAL  = '0
) (
  input  logic             clk,
  input  logic             rst,
  output logic             busy,
  input  logic             a_ce,
  input  logic [DW/8-1:0]  a_we,
  input  logic             a_oe,
  input  logic [AW-1:0]    a_addr,
  input  logic [DW-1:0]    a_di,
  output logic [DW-1:0]    a_do,
  input  logic             b_ce,
  input  logic             b_oe,
  input  logic [AW-1:0]    b_addr,
  output logic [DW-1:0]    b_do
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << AW;

  logic [DW-1:0] mem [0:DEPTH-1];

  logic          clr_we;
  logic [AW-1:0] clr_addr;

  if (CLEAR_ON_RST != 0) begin : g_clear
    dpram_be_clear_seq #(.AW(AW)) u_clear_seq (
      .clk      (clk),
      .rst      (rst),
      .busy     (busy),
      .clr_we   (clr_we),
      .clr_addr (clr_addr)
    );
  end else begin : g_no_clear
    assign busy     = 1'b0;
    assign clr_we   = 1'b0;
    assign clr_addr = '0;
  end

  logic          a_acc, b_acc, a_wr;
  logic [DW-1:0] a_old, b_old, a_merged;

  assign a_acc = a_ce & ~busy;
  assign b_acc = b_ce & ~busy;
  assign a_wr  = a_acc & (|a_we);
  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  always_comb begin
    a_merged = a_old;
    for (int i = 0; i < NB; i++)
      a_merged[8*i +: 8] = byte_merge(a_old[8*i +: 8], a_di[8*i +: 8], a_we[i]);
  end

  // Single array, one write process, per-lane enables: keeps block-RAM inference intact.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem[clr_addr] <= CLEAR_VAL;
    end else if (a_wr) begin
      for (int i = 0; i < NB; i++)
        if (a_we[i]) mem[a_addr][8*i +: 8] <= a_di[8*i +: 8];
    end
  end

  logic [DW-1:0] a_rd_q, a_rd_d, b_rd_q, b_rd_d;
  logic          a_oe_q, a_oe_d, b_oe_q, b_oe_d;

  // Read data is captured only on an accepted enable, so ce=0 replays the last word.
  always_comb begin
    a_rd_d = a_rd_q;
    b_rd_d = b_rd_q;
    if (a_acc)
      a_rd_d = (RDW_MODE == RDW_WRITE_FIRST && a_wr) ? a_merged : a_old;
    if (b_acc)
      b_rd_d = (RDW_MODE == RDW_WRITE_FIRST && a_wr && b_addr == a_addr) ? a_merged : b_old;
    a_oe_d = a_oe & ~busy;
    b_oe_d = b_oe & ~busy;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_rd_q <= '0;
      b_rd_q <= '0;
      a_oe_q <= 1'b0;
      b_oe_q <= 1'b0;
    end else begin
      a_rd_q <= a_rd_d;
      b_rd_q <= b_rd_d;
      a_oe_q <= a_oe_d;
      b_oe_q <= b_oe_d;
    end
  end

  logic [DW-1:0] a_stage, b_stage;
  assign a_stage = a_oe_q ? a_rd_q : '0;
  assign b_stage = b_oe_q ? b_rd_q : '0;

  if (OUT_REG != 0) begin : g_out_reg
    logic [DW-1:0] a_out_q, a_out_d, b_out_q, b_out_d;
    assign a_out_d = a_stage;
    assign b_out_d = b_stage;
    always_ff @(posedge clk) begin
      if (rst) begin
        a_out_q <= '0;
        b_out_q <= '0;
      end else begin
        a_out_q <= a_out_d;
        b_out_q <= b_out_d;
      end
    end
    assign a_do = a_out_q;
    assign b_do = b_out_q;
  end else begin : g_no_out_reg
    assign a_do = a_stage;
    assign b_do = b_stage;
  end

endmodule
`default_nettype wire
